program_fetch: RTL and testbench

Upstream neighbour of the 8-bit core's control unit. Holds the 12-bit program counter and the 16-bit-wide program memory, and presents `instruction` for the control unit to latch in its FETCH state. It also contains the bootstrap loader. The loader fills program memory from a byte stream over a valid/ready handshake. While loading it drives `bootstrapping` and freezes the PC.

---
 rtl/uc_pkg.sv | 25 ++
 rtl/boot_loader.sv | 150 +++++++++++++++
 rtl/program_fetch.sv | 91 +++++++++
 tb/tb_program_fetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the program-fetch slice: datapath widths, the
// loader state encoding and the length-assembly helper.
package uc_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 16;
  localparam int LEN_W   = 13;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    BL_IDLE    = 3'd0,
    BL_LEN_HI  = 3'd1,
    BL_LEN_LO  = 3'd2,
    BL_DATA_HI = 3'd3,
    BL_DATA_LO = 3'd4
  } boot_state_e;

  // Word count is big-endian; only the low 13 bits of the 16-bit field matter.
  function automatic logic [LEN_W-1:0] boot_len(input logic [4:0] hi,
                                                input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/boot_loader.sv
// Bootstrap loader: receives a length-prefixed byte stream over valid/ready
// and turns it into 16-bit program-memory writes.
module boot_loader
  import uc_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               boot_start,
  input  logic [7:0]         boot_data,
  input  logic               boot_valid,
  output logic               boot_ready,
  output logic               bootstrapping,
  output logic               boot_done,
  output logic               boot_err,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               pc_clear
);

  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(MEM_DEPTH);

  boot_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] addr_q, addr_d;
  logic [7:0]       hi_q, hi_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept_s;
  logic [LEN_W-1:0] len_rx_s;
  logic [LEN_W-1:0] addr_inc_s;

  assign accept_s   = boot_valid & ready_q;
  assign len_rx_s   = boot_len(len_q[LEN_W-1:8], boot_data);
  assign addr_inc_s = addr_q + 13'd1;

  // Writes are issued on the accepting edge itself so the word is readable next cycle.
  assign wr_addr = addr_q[AW-1:0];
  assign wr_data = {hi_q, boot_data};

  assign boot_ready    = ready_q;
  assign bootstrapping = busy_q;
  assign boot_done     = done_q;
  assign boot_err      = err_q;

  // Next-state, counter and strobe logic for the loader FSM.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    err_d    = err_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    pc_clear = 1'b0;
    case (state_q)
      BL_IDLE: begin
        if (boot_start) begin
          state_d = BL_LEN_HI;
          err_d   = 1'b0;
        end else begin
          state_d = BL_IDLE;
        end
      end
      BL_LEN_HI: begin
        if (accept_s) begin
          len_d   = {boot_data[4:0], 8'h00};
          state_d = BL_LEN_LO;
        end else begin
          state_d = BL_LEN_HI;
        end
      end
      BL_LEN_LO: begin
        if (accept_s) begin
          len_d = len_rx_s;
          if (len_rx_s > DEPTH_LEN) begin
            err_d   = 1'b1;
            state_d = BL_IDLE;
          end else if (len_rx_s == 13'd0) begin
            done_d   = 1'b1;
            pc_clear = 1'b1;
            state_d  = BL_IDLE;
          end else begin
            addr_d  = 13'd0;
            state_d = BL_DATA_HI;
          end
        end else begin
          state_d = BL_LEN_LO;
        end
      end
      BL_DATA_HI: begin
        if (accept_s) begin
          hi_d    = boot_data;
          state_d = BL_DATA_LO;
        end else begin
          state_d = BL_DATA_HI;
        end
      end
      BL_DATA_LO: begin
        if (accept_s) begin
          wr_en  = 1'b1;
          addr_d = addr_inc_s;
          if (addr_inc_s == len_q) begin
            done_d   = 1'b1;
            pc_clear = 1'b1;
            state_d  = BL_IDLE;
          end else begin
            state_d = BL_DATA_HI;
          end
        end else begin
          state_d = BL_DATA_LO;
        end
      end
      default: begin
        state_d = BL_IDLE;
      end
    endcase
    ready_d = (state_d != BL_IDLE);
    busy_d  = (state_d != BL_IDLE);
  end

  // Loader state and registered handshake/status outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= BL_IDLE;
      len_q   <= 13'd0;
      addr_q  <= 13'd0;
      hi_q    <= 8'h00;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/program_fetch.sv
// Program counter, program memory and fetch mux for the 8-bit core, with the
// bootstrap loader as the only memory writer.
module program_fetch
  import uc_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               pc_inc,
  input  logic               pc_load,
  input  logic [PC_W-1:0]    pc_next,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  input  logic               boot_start,
  input  logic [7:0]         boot_data,
  input  logic               boot_valid,
  output logic               boot_ready,
  output logic               bootstrapping,
  output logic               boot_done,
  output logic               boot_err
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [PC_W:0] DEPTH_PC = (PC_W+1)'(MEM_DEPTH);

  logic [INSTR_W-1:0] mem [MEM_DEPTH];
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               wr_en_s;
  logic [AW-1:0]      wr_addr_s;
  logic [INSTR_W-1:0] wr_data_s;
  logic               pc_clear_s;
  logic               pc_in_range_s;

  boot_loader #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_boot_loader (
    .clk           (clk),
    .arst          (arst),
    .boot_start    (boot_start),
    .boot_data     (boot_data),
    .boot_valid    (boot_valid),
    .boot_ready    (boot_ready),
    .bootstrapping (bootstrapping),
    .boot_done     (boot_done),
    .boot_err      (boot_err),
    .wr_en         (wr_en_s),
    .wr_addr       (wr_addr_s),
    .wr_data       (wr_data_s),
    .pc_clear      (pc_clear_s)
  );

  // Addresses beyond the implemented depth fetch a NOP rather than aliasing.
  assign pc_in_range_s = ({1'b0, pc_q} < DEPTH_PC);
  assign instruction   = pc_in_range_s ? mem[pc_q[AW-1:0]] : NOP_WORD;
  assign pc            = pc_q;

  // Next PC: loader completion wins, the PC is frozen while loading, load beats increment.
  always_comb begin
    pc_d = pc_q;
    if (pc_clear_s) begin
      pc_d = 12'h000;
    end else if (bootstrapping) begin
      pc_d = pc_q;
    end else if (pc_load) begin
      pc_d = pc_next;
    end else if (pc_inc) begin
      pc_d = pc_q + 12'h001;
    end else begin
      pc_d = pc_q;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pc_q <= 12'h000;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_addr_s] <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_program_fetch.sv
// Directed bench for program_fetch: PC stepping, load priority and wrap,
// bootstrap loads at full rate and with gaps, bad length, reset mid-load.
module tb_program_fetch;

  logic        clk;
  logic        arst;
  logic        pc_inc;
  logic        pc_load;
  logic [11:0] pc_next;
  logic [15:0] instruction;
  logic [11:0] pc;
  logic        boot_start;
  logic [7:0]  boot_data;
  logic        boot_valid;
  logic        boot_ready;
  logic        bootstrapping;
  logic        boot_done;
  logic        boot_err;

  int checks = 0;
  int errors = 0;

  program_fetch #(.MEM_DEPTH(256)) dut (
    .clk           (clk),
    .arst          (arst),
    .pc_inc        (pc_inc),
    .pc_load       (pc_load),
    .pc_next       (pc_next),
    .instruction   (instruction),
    .pc            (pc),
    .boot_start    (boot_start),
    .boot_data     (boot_data),
    .boot_valid    (boot_valid),
    .boot_ready    (boot_ready),
    .bootstrapping (bootstrapping),
    .boot_done     (boot_done),
    .boot_err      (boot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] s_ok  [8] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h70, 8'h01};
  logic [7:0] s_mid [6] = '{8'h00, 8'h03, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    logic [11:0] pc_mid;

    arst = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; pc_next = 12'h000;
    boot_start = 1'b0; boot_data = 8'h00; boot_valid = 1'b0;

    // Reset and step
    #2 arst = 1'b1;
    #2;
    chk("rst_pc", {4'h0, pc}, 16'h0000);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_flags", {12'h000, boot_ready, bootstrapping, boot_done, boot_err}, 16'h0000);
    #8 arst = 1'b0;
    pc_inc = 1'b1;
    tick(); chk("step_pc1", {4'h0, pc}, 16'h0001);
    tick(); chk("step_pc2", {4'h0, pc}, 16'h0002);
    tick(); chk("step_pc3", {4'h0, pc}, 16'h0003);
    chk("step_instr", instruction, 16'h0000);

    // Load beats increment, then wrap
    pc_load = 1'b1; pc_next = 12'hFFF;
    tick();
    pc_load = 1'b0;
    chk("load_fff", {4'h0, pc}, 16'h0FFF);
    tick();
    pc_inc = 1'b0;
    chk("wrap_000", {4'h0, pc}, 16'h0000);

    // Boot three words at full rate with pc_inc noise
    pc_load = 1'b1; pc_next = 12'h005;
    tick();
    pc_load = 1'b0;
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    chk("boot_ready_t1", {15'h0, boot_ready}, 16'h0001);
    busy_cnt = 0;
    pc_mid = 12'h000;
    for (int i = 0; i < 8; i++) begin
      if (bootstrapping) busy_cnt++;
      boot_valid = 1'b1;
      boot_data  = s_ok[i];
      pc_inc     = (i % 2 == 1) ? 1'b1 : 1'b0;
      if (i == 7) pc_mid = pc;
      tick();
    end
    boot_valid = 1'b0; pc_inc = 1'b0;
    chk("boot_busy_cycles", 16'(busy_cnt), 16'd8);
    chk("boot_pc_frozen", {4'h0, pc_mid}, 16'h0005);
    chk("boot_done_pulse", {15'h0, boot_done}, 16'h0001);
    chk("boot_pc_cleared", {4'h0, pc}, 16'h0000);
    chk("boot_busy_dropped", {15'h0, bootstrapping}, 16'h0000);
    tick();
    chk("boot_done_once", {15'h0, boot_done}, 16'h0000);
    chk("boot_mem0", instruction, 16'h1234);
    pc_inc = 1'b1;
    tick(); chk("boot_mem1", instruction, 16'hABCD);
    tick(); chk("boot_mem2", instruction, 16'h7001);
    pc_inc = 1'b0;

    // Bad length 0x0101 > 256
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    boot_valid = 1'b1; boot_data = 8'h01;
    tick();
    boot_data = 8'h01;
    tick();
    boot_valid = 1'b0;
    chk("bad_err", {15'h0, boot_err}, 16'h0001);
    chk("bad_idle", {14'h0, boot_ready, bootstrapping}, 16'h0000);
    chk("bad_no_done", {15'h0, boot_done}, 16'h0000);
    chk("bad_pc_kept", {4'h0, pc}, 16'h0002);
    chk("bad_mem2_kept", instruction, 16'h7001);
    pc_load = 1'b1; pc_next = 12'h000;
    tick();
    pc_load = 1'b0;
    chk("bad_mem0_kept", instruction, 16'h1234);
    chk("bad_err_sticky", {15'h0, boot_err}, 16'h0001);
    pc_inc = 1'b1; tick(); tick(); pc_inc = 1'b0;

    // Backpressure: valid every other cycle, junk data in the gaps
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    chk("gap_err_cleared", {15'h0, boot_err}, 16'h0000);
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 0; c < 16; c++) begin
      if (boot_done) begin
        done_cnt++;
        done_cyc = c;
      end
      boot_valid = (c % 2 == 0) ? 1'b1 : 1'b0;
      boot_data  = (c % 2 == 0) ? s_ok[c / 2] : 8'hEE;
      tick();
    end
    boot_valid = 1'b0;
    chk("gap_done_count", 16'(done_cnt), 16'd1);
    chk("gap_done_cycle", 16'(done_cyc), 16'd15);
    chk("gap_pc", {4'h0, pc}, 16'h0000);
    chk("gap_mem0", instruction, 16'h1234);
    pc_inc = 1'b1;
    tick(); chk("gap_mem1", instruction, 16'hABCD);
    tick(); chk("gap_mem2", instruction, 16'h7001);
    pc_inc = 1'b0;

    // Reset after four data bytes
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      boot_valid = 1'b1;
      boot_data  = s_mid[i];
      tick();
    end
    boot_valid = 1'b0;
    #2 arst = 1'b1;
    #1;
    chk("mid_rst_idle", {14'h0, boot_ready, bootstrapping}, 16'h0000);
    chk("mid_rst_pc", {4'h0, pc}, 16'h0000);
    arst = 1'b0;
    tick();
    chk("mid_mem0_new", instruction, 16'h5566);
    chk("mid_still_idle", {15'h0, boot_ready}, 16'h0000);
    pc_inc = 1'b1;
    tick(); chk("mid_mem1_new", instruction, 16'h7788);
    tick(); chk("mid_mem2_old", instruction, 16'h7001);
    pc_inc = 1'b0;

    // Out-of-range fetch
    pc_load = 1'b1; pc_next = 12'h100;
    tick();
    pc_load = 1'b0;
    chk("oor_pc", {4'h0, pc}, 16'h0100);
    chk("oor_nop", instruction, 16'h0000);

    // Zero-length load completes with no writes
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    boot_valid = 1'b1; boot_data = 8'h00;
    tick();
    tick();
    boot_valid = 1'b0;
    chk("zero_done", {15'h0, boot_done}, 16'h0001);
    chk("zero_pc", {4'h0, pc}, 16'h0000);
    chk("zero_flags", {14'h0, bootstrapping, boot_err}, 16'h0000);
    chk("zero_mem0", instruction, 16'h5566);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
